// File: rtl/box_anim_pkg.sv
// Shared types and constants for the bouncing-box animation controller.
package box_anim_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD_X,
    S_LOAD_Y,
    S_DRAW,
    S_WAIT,
    S_ERASE,
    S_MOVE
  } state_e;

  // One burst covers the 4x4 box; the datapath's 4-bit pixel counter wraps on it.
  localparam int BOX_PIXELS = 16;
  localparam int SCREEN_W   = 160;
  localparam int SCREEN_H   = 120;

  // Result of one bounce step along a single axis.
  typedef struct packed {
    logic       neg;  // 1: moving toward 0
    logic [7:0] pos;
  } move_t;

  // Advance one axis by one pixel, reflecting at 0 and at max.
  // The reflection lands one pixel inside, so the position never leaves 0..max.
  function automatic move_t bounce_step(input logic [7:0] pos,
                                        input logic       neg,
                                        input logic [7:0] max);
    move_t r;
    if (!neg && pos == max) begin
      r.neg = 1'b1;
      r.pos = max - 8'd1;
    end else if (neg && pos == 8'd0) begin
      r.neg = 1'b0;
      r.pos = 8'd1;
    end else if (neg) begin
      r.neg = 1'b1;
      r.pos = pos - 8'd1;
    end else begin
      r.neg = 1'b0;
      r.pos = pos + 8'd1;
    end
    return r;
  endfunction

endpackage

// File: rtl/box_anim_ctrl_frame_tick_gen.sv
// Free-running frame tick: counts 0..FRAME_TICKS-1 and pulses tick for the
// single cycle in which the counter wraps.
module frame_tick_gen #(
  parameter int FRAME_TICKS = 833333
) (
  input  logic clock,
  input  logic reset,
  output logic tick
);

  localparam int CW = (FRAME_TICKS > 1) ? $clog2(FRAME_TICKS) : 1;

  logic [CW-1:0] cnt_q, cnt_d;

  // Wrap detection and next count.
  always_comb begin
    tick  = (cnt_q == CW'(FRAME_TICKS - 1));
    cnt_d = tick ? '0 : cnt_q + 1'b1;
  end

  // Counter register.
  always_ff @(posedge clock) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/box_anim_ctrl.sv
// Bouncing-box animation sequencer: load_x, load_y, 16-cycle draw, wait a
// number of frames, 16-cycle erase, move one pixel diagonally, repeat.
// Optional macro BOX_ANIM_PAUSE_EN adds a pause input that freezes the
// frame count while the box is shown.
module box_anim_ctrl
  import box_anim_pkg::*;
#(
  parameter int FRAME_TICKS     = 833333,
  parameter int FRAMES_PER_MOVE = 15,
  parameter int X_MAX           = 156,
  parameter int Y_MAX           = 116
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       go,
  output logic [7:0] x_pos,
  output logic [6:0] y_pos,
  output logic       load_x,
  output logic       load_y,
  output logic       draw,
  output logic       erase,
  output logic       plot,
`ifdef BOX_ANIM_PAUSE_EN
  output logic       busy,
  input  logic       pause
`else
  output logic       busy
`endif
);

  localparam int FW = $clog2(FRAMES_PER_MOVE + 1);

  logic pause_w;
`ifdef BOX_ANIM_PAUSE_EN
  assign pause_w = pause;
`else
  assign pause_w = 1'b0;
`endif

  state_e        state_q, state_d;
  logic [7:0]    x_q, x_d;
  logic [6:0]    y_q, y_d;
  logic          dxn_q, dxn_d;  // 1: moving left
  logic          dyn_q, dyn_d;  // 1: moving up
  logic [3:0]    pix_q, pix_d;
  logic [FW-1:0] frame_q, frame_d;
  logic          tick;
  move_t         mv_x, mv_y;

  frame_tick_gen #(.FRAME_TICKS(FRAME_TICKS)) u_tick (
    .clock (clock),
    .reset (reset),
    .tick  (tick)
  );

  assign mv_x = bounce_step(x_q, dxn_q, 8'(X_MAX));
  assign mv_y = bounce_step({1'b0, y_q}, dyn_q, 8'(Y_MAX));

  assign x_pos = x_q;
  assign y_pos = y_q;

  // Next-state, counters, position update and Moore strobes.
  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    dxn_d   = dxn_q;
    dyn_d   = dyn_q;
    pix_d   = pix_q;
    frame_d = frame_q;
    load_x  = 1'b0;
    load_y  = 1'b0;
    draw    = 1'b0;
    erase   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (go) state_d = S_LOAD_X;
      end
      S_LOAD_X: begin
        load_x  = 1'b1;
        state_d = S_LOAD_Y;
      end
      S_LOAD_Y: begin
        load_y  = 1'b1;
        pix_d   = '0;
        state_d = S_DRAW;
      end
      S_DRAW: begin
        draw  = 1'b1;
        pix_d = pix_q + 4'd1;
        if (pix_q == 4'(BOX_PIXELS - 1)) begin
          frame_d = '0;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        // Ticks count only here; pause freezes the frame count.
        if (tick && !pause_w) begin
          frame_d = frame_q + 1'b1;
          if (frame_q + 1'b1 == FW'(FRAMES_PER_MOVE)) begin
            pix_d   = '0;
            state_d = S_ERASE;
          end
        end
      end
      S_ERASE: begin
        erase = 1'b1;
        pix_d = pix_q + 4'd1;
        if (pix_q == 4'(BOX_PIXELS - 1)) state_d = S_MOVE;
      end
      S_MOVE: begin
        x_d     = mv_x.pos;
        dxn_d   = mv_x.neg;
        y_d     = 7'(mv_y.pos);
        dyn_d   = mv_y.neg;
        state_d = go ? S_LOAD_X : S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    plot = draw | erase;
    busy = (state_q != S_IDLE);
  end

  // State and datapath registers; reset overrides any burst in progress.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_IDLE;
      x_q     <= '0;
      y_q     <= '0;
      dxn_q   <= 1'b0;
      dyn_q   <= 1'b0;
      pix_q   <= '0;
      frame_q <= '0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      dxn_q   <= dxn_d;
      dyn_q   <= dyn_d;
      pix_q   <= pix_d;
      frame_q <= frame_d;
    end
  end

endmodule

// File: tb/tb_box_anim_ctrl.sv
// Bench for box_anim_ctrl: random go activity checked against a round-level
// model (triangle-wave positions, tick schedule from cycles since reset).
module tb_box_anim_ctrl;
  localparam int FT = 4, FPM = 2, XM = 156, YM = 116;

  logic clock = 1'b0, reset = 1'b1, go = 1'b0;
`ifdef BOX_ANIM_PAUSE_EN
  logic pause = 1'b0;
`endif
  logic [7:0] x_pos;
  logic [6:0] y_pos;
  logic load_x, load_y, draw, erase, plot, busy;

  int checks = 0, failures = 0;
  int tcnt = 0;  // cycles since last reset = expected tick counter value
  int k = 0;     // moves since reset

  box_anim_ctrl #(.FRAME_TICKS(FT), .FRAMES_PER_MOVE(FPM), .X_MAX(XM), .Y_MAX(YM)) dut (
    .clock (clock), .reset (reset), .go (go),
    .x_pos (x_pos), .y_pos (y_pos),
    .load_x(load_x), .load_y(load_y), .draw(draw), .erase(erase),
    .plot  (plot),
`ifdef BOX_ANIM_PAUSE_EN
    .busy  (busy), .pause(pause)
`else
    .busy  (busy)
`endif
  );

  always #5 clock = ~clock;
  always @(posedge clock) if (reset) tcnt <= 0; else tcnt <= tcnt + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h (t=%0d k=%0d)", tag, got, exp, tcnt, k);
    end
  endtask

  task automatic step();
    @(posedge clock); #1;
  endtask

  // Diagonal bounce is a triangle wave of the move count.
  function automatic int refl(input int kk, input int m);
    int p;
    p = kk % (2 * m);
    return (p <= m) ? p : 2 * m - p;
  endfunction

  // Cycle index of the n-th tick at or after cycle s.
  function automatic int tick_cycle(input int s, input int n);
    int seen = 0;
    for (int c = s; c < s + FT * (n + 1); c++)
      if (c % FT == FT - 1) begin
        seen++;
        if (seen == n) return c;
      end
    return -1;
  endfunction

  task automatic chk_out(input string tag, input bit lx, input bit ly,
                         input bit dr, input bit er, input bit bz);
    chk(tag, {26'd0, load_x, load_y, draw, erase, plot, busy},
             {26'd0, lx, ly, dr, er, dr | er, bz});
  endtask

  task automatic chk_pos(input string tag);
    chk({tag, "_x"}, x_pos, refl(k, XM));
    chk({tag, "_y"}, y_pos, refl(k, YM));
  endtask

  // One full animation round, entered with LOAD_X due at the next edge.
  task automatic do_round(input bit stay_go, input bit drop_go,
                          input int rst_at, input bit do_pause);
    int t_end, c2;
    step; chk_out("ldx", 1, 0, 0, 0, 1); chk_pos("ldx");
    go = 1'($urandom_range(0, 1));
    step; chk_out("ldy", 0, 1, 0, 0, 1); chk_pos("ldy");
    go = 1'($urandom_range(0, 1));
    for (int i = 0; i < 16; i++) begin
      step; chk_out("draw", 0, 0, 1, 0, 1); chk_pos("draw");
      go = drop_go ? 1'b0 : 1'($urandom_range(0, 1));
      if (i == rst_at) begin
        reset = 1'b1; go = 1'b0;
        step; k = 0;
        chk_out("rst_mid", 0, 0, 0, 0, 0); chk_pos("rst_mid");
        reset = 1'b0;
        step; chk_out("rst_idle", 0, 0, 0, 0, 0); chk_pos("rst_idle");
        return;
      end
    end
    t_end = tcnt;
    c2 = tick_cycle(t_end + 1, FPM);
`ifdef BOX_ANIM_PAUSE_EN
    if (do_pause) begin
      pause = 1'b1;
      for (int i = 0; i < 20 * FT; i++) begin
        step; chk_out("paused", 0, 0, 0, 0, 1);
      end
      pause = 1'b0;
      c2 = tick_cycle(tcnt + 1, FPM);
    end
`else
    if (do_pause) c2 = tick_cycle(t_end + 1, FPM);
`endif
    while (tcnt < c2) begin
      step; chk_out("wait", 0, 0, 0, 0, 1); chk_pos("wait");
      go = 1'($urandom_range(0, 1));
    end
    for (int i = 0; i < 16; i++) begin
      step; chk_out("erase", 0, 0, 0, 1, 1); chk_pos("erase");
      go = 1'($urandom_range(0, 1));
    end
    step; chk_out("move", 0, 0, 0, 0, 1); chk_pos("move");
    go = stay_go; k++;
    if (!stay_go) begin
      step; chk_out("idle", 0, 0, 0, 0, 0); chk_pos("idle");
    end
  endtask

  initial begin
    int r;
    bit stay;
    reset = 1'b1;
    repeat (3) step;
    chk_out("reset", 0, 0, 0, 0, 0); chk_pos("reset");
    reset = 1'b0;
    step; chk_out("pre_go", 0, 0, 0, 0, 0);
    go = 1'b1;
    r = 0;
    while (k < 316 && r < 400) begin
      if (r == 2) begin
        do_round(1'b0, 1'b1, -1, 1'b0);
        repeat (3) begin step; chk_out("parked", 0, 0, 0, 0, 0); chk_pos("parked"); end
        go = 1'b1;
      end else if (r == 4) begin
        do_round(1'b1, 1'b0, 6, 1'b0);
        go = 1'b1;
      end else begin
        stay = ($urandom_range(0, 15) != 0);
        do_round(stay, 1'b0, -1, (r == 1));
        if (!stay) begin
          repeat ($urandom_range(0, 4)) begin
            step; chk_out("idle_hold", 0, 0, 0, 0, 0); chk_pos("idle_hold");
          end
          go = 1'b1;
        end
      end
      r++;
    end
    chk("move_count", k, 316);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
